// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter and its round-robin picker.
package fifo_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

    localparam int ARB_NREQ_DEFAULT = 4;

    // Requester-id width; a single producer still gets a 1-bit id.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Next position after ptr in a ring of n requesters.
    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1) % n;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request after ptr_i, wrapping.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = ARB_NREQ_DEFAULT,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic            any_o,
    output logic [IDW-1:0]  idx_o
);

    always_comb begin
        int   pos;
        logic found;
        pos   = int'(ptr_i);
        found = 1'b0;
        idx_o = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = rr_next(pos, NREQ);
            for (int j = 0; j < NREQ; j++) begin
                if (!found && (j == pos) && req_i[j]) begin
                    found = 1'b1;
                    idx_o = IDW'(j);
                end
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked sharing of one sync_fifo write port among NREQ producers.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = ARB_NREQ_DEFAULT,
    parameter int DWIDTH    = 16,
    parameter int MAX_BURST = 8,
    parameter int IDLE_TO   = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_last,
    input  logic [NREQ*DWIDTH-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     fifo_full,
    output logic                     fifo_wr_en,
    output logic [DWIDTH-1:0]        fifo_din,
    output logic [id_width(NREQ)-1:0] grant_id,
    output logic                     busy
);

    localparam int IDW = id_width(NREQ);
    localparam int BCW = $clog2(MAX_BURST + 1);
    localparam int ICW = $clog2(IDLE_TO + 1);

    arb_state_t      state_q, state_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [BCW-1:0]  beat_cnt_q, beat_cnt_d;
    logic [ICW-1:0]  idle_cnt_q, idle_cnt_d;

    logic              pick_any;
    logic [IDW-1:0]    pick_idx;
    logic              own_valid;
    logic              own_last;
    logic [DWIDTH-1:0] own_data;

    rr_picker #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_picker (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == IDW'(i)) begin
                own_valid = req_valid[i];
                own_last  = req_last[i];
                own_data  = req_data[i*DWIDTH +: DWIDTH];
            end
        end
    end

    always_comb begin
        busy       = (state_q == ARB_BURST);
        grant_id   = owner_q;
        fifo_wr_en = busy && own_valid && !fifo_full;
        fifo_din   = busy ? own_data : '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = busy && (owner_q == IDW'(i)) && !fifo_full;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        idle_cnt_d = idle_cnt_q;
        if (state_q == ARB_IDLE) begin
            if (pick_any) begin
                state_d = ARB_BURST;
                owner_d = pick_idx;
            end
        end else if (fifo_wr_en) begin
            idle_cnt_d = '0;
            if (own_last || (beat_cnt_q == BCW'(MAX_BURST - 1))) begin
                state_d    = ARB_IDLE;
                rr_ptr_d   = owner_q;
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + BCW'(1);
            end
        end else if (own_valid) begin
            // Stalled on a full FIFO: the owner is still active, so no timeout progress.
            idle_cnt_d = '0;
        end else if (idle_cnt_q == ICW'(IDLE_TO - 1)) begin
            state_d    = ARB_IDLE;
            rr_ptr_d   = owner_q;
            beat_cnt_d = '0;
            idle_cnt_d = '0;
        end else begin
            idle_cnt_d = idle_cnt_q + ICW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ARB_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= IDW'(NREQ - 1);
            beat_cnt_q <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

endmodule
